// File: rtl/ace_snoop_resp_mux_if.sv
// Signal bundle for ace_snoop_resp_mux: the normal and devil snoop-response sources,
// the merged ACE CR/CD channel toward the interconnect, and the status outputs.
interface ace_snoop_resp_mux_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  i_devil_sel;
    logic [4:0]            i_n_crresp;
    logic                  i_n_crvalid;
    logic                  o_n_crready;
    logic [DATA_WIDTH-1:0] i_n_cddata;
    logic                  i_n_cdvalid;
    logic                  i_n_cdlast;
    logic                  o_n_cdready;
    logic [4:0]            i_d_crresp;
    logic                  i_d_crvalid;
    logic                  o_d_crready;
    logic [DATA_WIDTH-1:0] i_d_cddata;
    logic                  i_d_cdvalid;
    logic                  i_d_cdlast;
    logic                  o_d_cdready;
    logic [4:0]            o_crresp;
    logic                  o_crvalid;
    logic                  i_crready;
    logic [DATA_WIDTH-1:0] o_cddata;
    logic                  o_cdvalid;
    logic                  o_cdlast;
    logic                  i_cdready;
    logic                  i_err_clr;
    logic                  o_owner;
    logic                  o_busy;
    logic                  o_len_err;
    logic [15:0]           o_resp_count;

    modport slave (
        input  i_devil_sel,
        input  i_n_crresp, i_n_crvalid, i_n_cddata, i_n_cdvalid, i_n_cdlast,
        output o_n_crready, o_n_cdready,
        input  i_d_crresp, i_d_crvalid, i_d_cddata, i_d_cdvalid, i_d_cdlast,
        output o_d_crready, o_d_cdready,
        output o_crresp, o_crvalid, o_cddata, o_cdvalid, o_cdlast,
        input  i_crready, i_cdready, i_err_clr,
        output o_owner, o_busy, o_len_err, o_resp_count
    );

    modport master (
        output i_devil_sel,
        output i_n_crresp, i_n_crvalid, i_n_cddata, i_n_cdvalid, i_n_cdlast,
        input  o_n_crready, o_n_cdready,
        output i_d_crresp, i_d_crvalid, i_d_cddata, i_d_cdvalid, i_d_cdlast,
        input  o_d_crready, o_d_cdready,
        input  o_crresp, o_crvalid, o_cddata, o_cdvalid, o_cdlast,
        output i_crready, i_cdready, i_err_clr,
        input  o_owner, o_busy, o_len_err, o_resp_count
    );
endinterface

// File: rtl/ace_snoop_resp_mux.sv
// Grants the normal or devil snoop responder the ACE CR/CD channel for one whole transaction.
// Optional macro SNOOP_RESP_SKID_EN adds a 2-entry skid buffer on the ACE CR and CD outputs.
module ace_snoop_resp_mux #(
    parameter int C_ACE_DATA_WIDTH = 128,
    parameter int CD_BEATS         = 4
) (
    input  logic                ace_aclk,
    input  logic                ace_areset,
    ace_snoop_resp_mux_if.slave bus
);
    localparam int                BEAT_W    = $clog2(CD_BEATS) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CD_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CR   = 2'd1,
        ST_CD   = 2'd2
    } state_t;

    state_t                      state_r;
    logic                        owner_r;
    logic                        busy_r;
    logic                        len_err_r;
    logic [BEAT_W-1:0]           beat_r;
    logic [15:0]                 count_r;

    logic [4:0]                  sel_crresp_s;
    logic                        sel_crvalid_s;
    logic [C_ACE_DATA_WIDTH-1:0] sel_cddata_s;
    logic                        sel_cdvalid_s;
    logic                        sel_cdlast_s;
    logic                        cr_ready_s;
    logic                        cd_ready_s;
    logic                        cr_hs_s;
    logic                        cd_hs_s;
    logic                        grant_ok_s;
    logic                        grant_devil_s;
    logic                        grant_normal_s;
    logic                        len_bad_s;
    logic                        count_inc_s;
    logic [4:0]                  ace_crresp_s;
    logic                        ace_crvalid_s;
    logic [C_ACE_DATA_WIDTH-1:0] ace_cddata_s;
    logic                        ace_cdvalid_s;
    logic                        ace_cdlast_s;

    // Route the current owner's CR/CD signals onto the internal select bus.
    always_comb begin
        if (owner_r) begin
            sel_crresp_s  = bus.i_d_crresp;
            sel_crvalid_s = bus.i_d_crvalid;
            sel_cddata_s  = bus.i_d_cddata;
            sel_cdvalid_s = bus.i_d_cdvalid;
            sel_cdlast_s  = bus.i_d_cdlast;
        end else begin
            sel_crresp_s  = bus.i_n_crresp;
            sel_crvalid_s = bus.i_n_crvalid;
            sel_cddata_s  = bus.i_n_cddata;
            sel_cdvalid_s = bus.i_n_cdvalid;
            sel_cdlast_s  = bus.i_n_cdlast;
        end
    end

    // Source-side handshakes; CD is only accepted once the CR phase has finished.
    assign cr_hs_s        = (state_r == ST_CR) && sel_crvalid_s && cr_ready_s;
    assign cd_hs_s        = (state_r == ST_CD) && sel_cdvalid_s && cd_ready_s;
    assign grant_devil_s  = bus.i_d_crvalid && (bus.i_devil_sel || !bus.i_n_crvalid);
    assign grant_normal_s = bus.i_n_crvalid;
    assign len_bad_s      = cd_hs_s && ((sel_cdlast_s && (beat_r != LAST_BEAT)) ||
                                        (!sel_cdlast_s && (beat_r == LAST_BEAT)));

`ifdef SNOOP_RESP_SKID_EN
    logic [4:0]                  cr_mem_r [2];
    logic                        cr_wp_r;
    logic                        cr_rp_r;
    logic [1:0]                  cr_cnt_r;
    logic [C_ACE_DATA_WIDTH:0]   cd_mem_r [2];
    logic                        cd_wp_r;
    logic                        cd_rp_r;
    logic [1:0]                  cd_cnt_r;
    logic                        cr_pop_s;
    logic                        cd_pop_s;

    // Buffer-fed ACE side; a new grant waits until both buffers have drained.
    always_comb begin
        cr_ready_s    = (state_r == ST_CR) && (cr_cnt_r != 2'd2);
        cd_ready_s    = (state_r == ST_CD) && (cd_cnt_r != 2'd2);
        grant_ok_s    = (cr_cnt_r == 2'd0) && (cd_cnt_r == 2'd0);
        ace_crvalid_s = (cr_cnt_r != 2'd0);
        ace_crresp_s  = ace_crvalid_s ? cr_mem_r[cr_rp_r] : 5'd0;
        ace_cdvalid_s = (cd_cnt_r != 2'd0);
        ace_cddata_s  = ace_cdvalid_s ? cd_mem_r[cd_rp_r][C_ACE_DATA_WIDTH-1:0]
                                      : {C_ACE_DATA_WIDTH{1'b0}};
        ace_cdlast_s  = ace_cdvalid_s && cd_mem_r[cd_rp_r][C_ACE_DATA_WIDTH];
        cr_pop_s      = ace_crvalid_s && bus.i_crready;
        cd_pop_s      = ace_cdvalid_s && bus.i_cdready;
        count_inc_s   = (cr_pop_s && !cr_mem_r[cr_rp_r][0]) || (cd_pop_s && ace_cdlast_s);
    end

    // Two-entry CR skid buffer.
    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            cr_mem_r[0] <= 5'd0;
            cr_mem_r[1] <= 5'd0;
            cr_wp_r     <= 1'b0;
            cr_rp_r     <= 1'b0;
            cr_cnt_r    <= 2'd0;
        end else begin
            if (cr_hs_s) begin
                cr_mem_r[cr_wp_r] <= sel_crresp_s;
                cr_wp_r           <= ~cr_wp_r;
            end
            if (cr_pop_s) begin
                cr_rp_r <= ~cr_rp_r;
            end
            case ({cr_hs_s, cr_pop_s})
                2'b10:   cr_cnt_r <= cr_cnt_r + 2'd1;
                2'b01:   cr_cnt_r <= cr_cnt_r - 2'd1;
                default: cr_cnt_r <= cr_cnt_r;
            endcase
        end
    end

    // Two-entry CD skid buffer; entries hold {last, data}.
    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            cd_mem_r[0] <= {(C_ACE_DATA_WIDTH + 1){1'b0}};
            cd_mem_r[1] <= {(C_ACE_DATA_WIDTH + 1){1'b0}};
            cd_wp_r     <= 1'b0;
            cd_rp_r     <= 1'b0;
            cd_cnt_r    <= 2'd0;
        end else begin
            if (cd_hs_s) begin
                cd_mem_r[cd_wp_r] <= {sel_cdlast_s, sel_cddata_s};
                cd_wp_r           <= ~cd_wp_r;
            end
            if (cd_pop_s) begin
                cd_rp_r <= ~cd_rp_r;
            end
            case ({cd_hs_s, cd_pop_s})
                2'b10:   cd_cnt_r <= cd_cnt_r + 2'd1;
                2'b01:   cd_cnt_r <= cd_cnt_r - 2'd1;
                default: cd_cnt_r <= cd_cnt_r;
            endcase
        end
    end
`else
    // Pass-through: the granted source talks to the ACE channel with no added latency.
    always_comb begin
        cr_ready_s    = (state_r == ST_CR) && bus.i_crready;
        cd_ready_s    = (state_r == ST_CD) && bus.i_cdready;
        grant_ok_s    = 1'b1;
        ace_crvalid_s = (state_r == ST_CR) && sel_crvalid_s;
        ace_crresp_s  = ace_crvalid_s ? sel_crresp_s : 5'd0;
        ace_cdvalid_s = (state_r == ST_CD) && sel_cdvalid_s;
        ace_cddata_s  = ace_cdvalid_s ? sel_cddata_s : {C_ACE_DATA_WIDTH{1'b0}};
        ace_cdlast_s  = ace_cdvalid_s && sel_cdlast_s;
        count_inc_s   = (cr_hs_s && !sel_crresp_s[0]) || (cd_hs_s && sel_cdlast_s);
    end
`endif

    // Transaction FSM: arbitrate in IDLE, hold the grant through CR and any CD burst.
    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            state_r <= ST_IDLE;
            owner_r <= 1'b0;
            busy_r  <= 1'b0;
            beat_r  <= {BEAT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_ok_s && grant_devil_s) begin
                        owner_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= ST_CR;
                    end else if (grant_ok_s && grant_normal_s) begin
                        owner_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_CR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CR: begin
                    if (cr_hs_s && sel_crresp_s[0]) begin
                        beat_r  <= {BEAT_W{1'b0}};
                        state_r <= ST_CD;
                    end else if (cr_hs_s) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CR;
                    end
                end
                ST_CD: begin
                    if (cd_hs_s) begin
                        beat_r <= beat_r + BEAT_W'(1);
                        if (sel_cdlast_s) begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky length error (a new violation beats a same-cycle clear) and completion counter.
    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            len_err_r <= 1'b0;
            count_r   <= 16'd0;
        end else begin
            if (len_bad_s) begin
                len_err_r <= 1'b1;
            end else if (bus.i_err_clr) begin
                len_err_r <= 1'b0;
            end
            if (count_inc_s) begin
                count_r <= count_r + 16'd1;
            end
        end
    end

    assign bus.o_crresp     = ace_crresp_s;
    assign bus.o_crvalid    = ace_crvalid_s;
    assign bus.o_cddata     = ace_cddata_s;
    assign bus.o_cdvalid    = ace_cdvalid_s;
    assign bus.o_cdlast     = ace_cdlast_s;
    assign bus.o_n_crready  = !owner_r && cr_ready_s;
    assign bus.o_d_crready  = owner_r && cr_ready_s;
    assign bus.o_n_cdready  = !owner_r && cd_ready_s;
    assign bus.o_d_cdready  = owner_r && cd_ready_s;
    assign bus.o_owner      = owner_r;
    assign bus.o_busy       = busy_r;
    assign bus.o_len_err    = len_err_r;
    assign bus.o_resp_count = count_r;
endmodule
